// File: rtl/tx_carrier_sense.sv
// Carrier sense for the TX path: windowed |I|+|Q| energy average compared against
// on/off thresholds with optional holdoff before the channel is declared clear.
module tx_carrier_sense #(
    parameter int BASE = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        set_stb,
    input  logic [7:0]  set_addr,
    input  logic [31:0] set_data,
    input  logic [31:0] rx_sample,
    input  logic        rx_strobe,
    output logic        carrier_present,
    output logic [31:0] carrier_present_nextcount,
    output logic [31:0] debug
);

    typedef enum logic [1:0] {
        DISABLED = 2'd0,
        CLEAR    = 2'd1,
        BUSY     = 2'd2,
        HOLDOFF  = 2'd3
    } state_t;

    localparam logic [7:0] ADDR_THR_ON  = 8'(BASE);
    localparam logic [7:0] ADDR_THR_OFF = 8'(BASE + 1);
    localparam logic [7:0] ADDR_CTRL    = 8'(BASE + 2);
    localparam logic [7:0] ADDR_HOLDOFF = 8'(BASE + 3);

    // |x| widened by one bit so that |-32768| = 32768 is representable
    function automatic logic [16:0] abs17(input logic signed [15:0] x);
        logic signed [16:0] xe;
        xe = {x[15], x};
        return x[15] ? 17'(-xe) : 17'(xe);
    endfunction

    logic [31:0] thr_on, thr_off, holdoff;
    logic        enable;
    logic [3:0]  win_log2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            thr_on   <= '0;
            thr_off  <= '0;
            holdoff  <= '0;
            enable   <= 1'b0;
            win_log2 <= '0;
        end else if (set_stb) begin
            if (set_addr == ADDR_THR_ON)  thr_on  <= set_data;
            if (set_addr == ADDR_THR_OFF) thr_off <= set_data;
            if (set_addr == ADDR_HOLDOFF) holdoff <= set_data;
            if (set_addr == ADDR_CTRL) begin
                enable   <= set_data[31];
                win_log2 <= set_data[3:0];
            end
        end
    end

    state_t state, state_nx;
    logic [31:0] holdcnt, holdcnt_nx, nextcount_nx;
    logic        cp_nx;

    // p0: magnitude and window accumulation on the strobe
    logic signed [15:0] i_p0, q_p0;
    logic [16:0] mag_p0;
    logic [31:0] acc_p0, acc_sum_p0;
    logic [15:0] cnt_p0;
    logic [16:0] win_len_p0;
    logic        last_p0;

    assign i_p0       = rx_sample[31:16];
    assign q_p0       = rx_sample[15:0];
    assign mag_p0     = abs17(i_p0) + abs17(q_p0);
    assign acc_sum_p0 = acc_p0 + {15'd0, mag_p0};
    assign win_len_p0 = 17'd1 << win_log2;
    // >= rather than == so a mid-window shrink of win_log2 still closes the window
    assign last_p0    = ({1'b0, cnt_p0} + 17'd1) >= win_len_p0;

    // p1: window average and its completion pulse
    logic [31:0] avg_p1;
    logic        vld_p1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_p0 <= '0;
            cnt_p0 <= '0;
            avg_p1 <= '0;
            vld_p1 <= 1'b0;
        end else if (clear) begin
            acc_p0 <= '0;
            cnt_p0 <= '0;
            avg_p1 <= '0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= 1'b0;
            if (state == DISABLED) begin
                acc_p0 <= '0;
                cnt_p0 <= '0;
            end else if (rx_strobe) begin
                if (last_p0) begin
                    avg_p1 <= acc_sum_p0 >> win_log2;
                    vld_p1 <= 1'b1;
                    acc_p0 <= '0;
                    cnt_p0 <= '0;
                end else begin
                    acc_p0 <= acc_sum_p0;
                    cnt_p0 <= cnt_p0 + 16'd1;
                end
            end
        end
    end

    // p2: channel state, registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                     <= DISABLED;
            holdcnt                   <= '0;
            carrier_present           <= 1'b0;
            carrier_present_nextcount <= '0;
        end else if (clear) begin
            state                     <= DISABLED;
            holdcnt                   <= '0;
            carrier_present           <= 1'b0;
            carrier_present_nextcount <= '0;
        end else begin
            state                     <= state_nx;
            holdcnt                   <= holdcnt_nx;
            carrier_present           <= cp_nx;
            carrier_present_nextcount <= nextcount_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        holdcnt_nx   = holdcnt;
        cp_nx        = 1'b0;
        nextcount_nx = '0;
        case (state)
            DISABLED: if (enable) state_nx = CLEAR;
            CLEAR:    if (vld_p1 && avg_p1 > thr_on) state_nx = BUSY;
            BUSY: begin
                if (vld_p1 && avg_p1 <= thr_off) begin
                    if (holdoff == 32'd0) begin
                        state_nx = CLEAR;
                    end else begin
                        state_nx   = HOLDOFF;
                        holdcnt_nx = holdoff;
                    end
                end
            end
            HOLDOFF: begin
                holdcnt_nx = holdcnt - 32'd1;
                // renewed energy takes priority over the holdoff expiring
                if (vld_p1 && avg_p1 > thr_off) begin
                    state_nx   = BUSY;
                    holdcnt_nx = '0;
                end else if (holdcnt <= 32'd1) begin
                    state_nx   = CLEAR;
                    holdcnt_nx = '0;
                end
            end
        endcase
        if (!enable) begin
            state_nx   = DISABLED;
            holdcnt_nx = '0;
        end
        cp_nx = (state_nx == BUSY) || (state_nx == HOLDOFF);
        if (state_nx == BUSY)         nextcount_nx = holdoff;
        else if (state_nx == HOLDOFF) nextcount_nx = holdcnt_nx;
    end

    assign debug = {state, carrier_present, 13'd0, avg_p1[15:0]};

endmodule

// File: doc/tx_carrier_sense.md
TX_CARRIER_SENSE -- requirements
Module: tx_carrier_sense

Interface
REQ-001 The module SHALL have parameter BASE, default 0, giving the settings-bus base address.
REQ-002 The module SHALL have input clk, 1 bit, the single clock; all logic is on its rising edge.
REQ-003 The module SHALL have input reset, 1 bit, asynchronous active-high reset.
REQ-004 The module SHALL have input clear, 1 bit, synchronous soft clear.
REQ-005 The module SHALL have inputs set_stb (1 bit), set_addr (8 bits) and set_data (32 bits), forming the settings bus.
REQ-006 The module SHALL have input rx_sample, 32 bits: I in [31:16] and Q in [15:0], both signed two's complement.
REQ-007 The module SHALL have input rx_strobe, 1 bit, marking rx_sample valid for one cycle.
REQ-008 The module SHALL have output carrier_present, 1 bit, registered, meaning the channel is busy; it feeds the TX controller.
REQ-009 The module SHALL have output carrier_present_nextcount, 32 bits, registered, giving the cycles remaining before the channel may be declared clear.
REQ-010 The module SHALL have output debug, 32 bits, equal to {state[1:0], carrier_present, 13'b0, avg[15:0]}.

Function
REQ-011 The module SHALL hold four settings registers, written when set_stb=1 and set_addr matches:
- BASE+0: thr_on[31:0]
- BASE+1: thr_off[31:0]
- BASE+2: enable = bit 31, win_log2 = bits [3:0]
- BASE+3: holdoff[31:0]
REQ-012 On each rx_strobe the module SHALL form mag = |I| + |Q| as 17 bits unsigned, with |-32768| = 32768.
REQ-013 The module SHALL add mag into a 32-bit accumulator and count strobes; the window is 2^win_log2 strobes, win_log2 = 0 means 1 strobe, and win_log2 > 15 is treated as 15. The accumulator cannot overflow.
REQ-014 On the strobe that completes a window, the module SHALL register avg = (acc + mag) >> win_log2 (zero-extended to 32 bits) in the next cycle, pulse win_done for 1 cycle, and restart the accumulator and counter from 0.
REQ-015 Latency SHALL be fixed: window-completing strobe at cycle N, then avg and win_done valid at N+1, then carrier_present and state updated at N+2.
REQ-016 The state machine SHALL have four states: DISABLED=0, CLEAR=1, BUSY=2, HOLDOFF=3.
REQ-017 DISABLED: carrier_present=0, nextcount=0, accumulator and counter held at 0; when enable=1, go to CLEAR.
REQ-018 CLEAR: on win_done with avg > thr_on, go to BUSY and set carrier_present=1.
REQ-019 BUSY: on win_done with avg <= thr_off:
- if holdoff=0, go to CLEAR with carrier_present=0;
- otherwise go to HOLDOFF and load holdcnt=holdoff.
REQ-020 HOLDOFF: carrier_present stays 1 and holdcnt decrements by 1 each clock.
- On win_done with avg > thr_off, go to BUSY.
- Otherwise, when holdcnt=1, go to CLEAR with carrier_present=0 and holdcnt=0.
REQ-021 When win_done with avg > thr_off coincides with holdcnt=1, the state SHALL go to BUSY (busy wins).
REQ-022 carrier_present_nextcount SHALL be 0 in DISABLED and CLEAR, holdoff in BUSY, and holdcnt in HOLDOFF.
REQ-023 When enable=0 in any state, the module SHALL go to DISABLED on the next clock, overriding all other transitions.
REQ-024 Comparisons SHALL be 32-bit unsigned; thr_on < thr_off is legal and is not checked.
REQ-025 A settings write mid-window SHALL take effect immediately; a win_log2 change does not restart the current window count.

Reset
REQ-026 Asynchronous reset SHALL force: state=DISABLED, carrier_present=0, nextcount=0, acc=0, count=0, avg=0, holdcnt=0, and all settings registers=0.
REQ-027 clear=1 SHALL clear state, acc, count, avg, holdcnt and the outputs as in REQ-026 on the next clock, while retaining the settings registers.
REQ-028 Reset asserted mid-window or in HOLDOFF SHALL discard all partial results; no carrier_present pulse follows reset release.

Verification
REQ-029 Threshold crossing: enable=1, win_log2=2, thr_on=1000, thr_off=500, holdoff=0; 4 strobes of I=Q=600 -> carrier_present=1 exactly 2 cycles after the 4th strobe; then 4 strobes of I=Q=100 -> carrier_present=0, nextcount=0.
REQ-030 Holdoff: as REQ-029 with holdoff=20 and no further strobes after the quiet window -> nextcount counts 20 down to 1, then carrier_present=0 on the following cycle.
REQ-031 Holdoff cancel: during HOLDOFF, a window of avg=800 (> thr_off) -> state=BUSY, carrier_present stays 1, nextcount=20.
REQ-032 Magnitude edge: win_log2=0, I=Q=-32768 -> avg=65536; with thr_on=65535 -> busy; with thr_on=65536 -> stays clear.
REQ-033 Disable and reset: enable cleared in BUSY -> carrier_present=0 one cycle later; async reset asserted mid-window -> all outputs 0 immediately, and the next window after release starts from count 0.
REQ-034 Simultaneous events: win_done with avg above thr_off in the same cycle as holdcnt=1 -> BUSY, carrier_present never drops.
